// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the MEM stage.
// Data requests win ties; a streak counter forces a fetch grant after MAX_D_STREAK
// consecutive data grants made while fetch was waiting.
// Ports: clk_i/rst_n_i (async active-low reset); if_req_i/if_addr_i -> if_rdata_o/if_done_o/if_stall_o;
// d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_rdata_o/d_done_o; mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o
// with mem_ack_i/mem_rdata_i; err_o sticky timeout flag.
// Build option: define ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog (err_o tied low otherwise).
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);
  state_t r_state, w_next;
  logic [SW-1:0] r_streak;
  logic r_own_d, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;
  logic w_busy, w_grant_d, w_grant_if, w_ack, w_timeout, w_end;
  assign w_busy     = (r_state == IF_BUSY) | (r_state == D_BUSY);
  assign w_grant_d  = d_req_i & (~if_req_i | (r_streak < MAX_S));
  assign w_grant_if = if_req_i & ~w_grant_d;
  assign w_ack      = w_busy & mem_ack_i;
  assign w_end      = w_ack | w_timeout;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt;
  logic r_err;
  // Counter is zero in IDLE, so every grant starts a fresh watchdog window.
  assign w_timeout = w_busy & ~mem_ack_i & (r_tcnt == TO_LAST);
  assign err_o     = r_err;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_busy ? r_tcnt + 1'b1 : '0;
      r_err  <= r_err | w_timeout;
    end
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:            w_next = w_grant_d ? D_BUSY : w_grant_if ? IF_BUSY : IDLE;
      IF_BUSY, D_BUSY: w_next = w_end ? DONE : r_state;
      default:         w_next = IDLE;
    endcase
  end
  always_comb begin
    mem_req_o = w_busy;
    if_done_o = (r_state == DONE) & ~r_own_d;
    d_done_o  = (r_state == DONE) & r_own_d;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_streak   <= '0;
      r_own_d    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_state == IDLE && (w_grant_d | w_grant_if)) begin
        r_own_d  <= w_grant_d;
        r_we     <= w_grant_d & d_we_i;
        r_addr   <= w_grant_d ? d_addr_i : if_addr_i;
        r_wdata  <= w_grant_d ? d_wdata_i : '0;
        // A data grant with fetch waiting implies streak < max, so +1 never overshoots.
        r_streak <= (w_grant_d & if_req_i) ? r_streak + 1'b1 : '0;
      end
      if (w_end & ~r_own_d) r_if_rdata <= w_timeout ? '0 : mem_rdata_i;
      if (r_own_d & ((w_ack & ~r_we) | w_timeout)) r_d_rdata <= w_timeout ? '0 : mem_rdata_i;
    end
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign if_rdata_o  = r_if_rdata;
  assign d_rdata_o   = r_d_rdata;
  assign if_stall_o  = if_req_i & ~if_done_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level reference model for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXD = 4, TO = 8;
  logic clk_i = 0, rst_n_i = 0, if_req_i = 0, d_req_i = 0, d_we_i = 0, mem_ack_i = 0;
  logic [AW-1:0] if_addr_i = 0, d_addr_i = 0;
  logic [DW-1:0] d_wdata_i = 0, mem_rdata_i = 0;
  logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic if_done_o, if_stall_o, d_done_o, mem_req_o, mem_we_o, err_o;
  int n_vec = 0, n_err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'h8C01_0004 : a * 3 + 32'h1000_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: acks after ack_delay waiting cycles; garbage on rdata outside the ack cycle.
  int ack_delay = 0, rcnt = 0;
  bit ack_en = 1, stray = 0;
  always @(negedge clk_i) begin
    if (mem_ack_i || !mem_req_o) begin
      mem_ack_i = 0; rcnt = 0; mem_rdata_i = 32'hBAD0_BAD0;
    end else if (ack_en && rcnt >= ack_delay) begin
      mem_ack_i = 1; mem_rdata_i = mem_val(mem_addr_o);
    end else rcnt++;
    if (stray) begin mem_ack_i = 1; stray = 0; end
  end

  // Reference model: phase 0 = free to grant, 1 = transaction in flight, 2 = completion cycle.
  int m_phase = 0, m_streak = 0, m_wait = 0;
  bit m_own_d = 0, m_we = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_d_rd = 0;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_phase = 0; m_streak = 0; m_wait = 0; m_own_d = 0; m_we = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_if_rd = 0; m_d_rd = 0;
    end else if (m_phase == 2) m_phase = 0;
    else if (m_phase == 1) begin
      m_wait++;
      if (mem_ack_i) begin
        m_phase = 2;
        if (!m_own_d) m_if_rd = mem_val(m_addr);
        else if (!m_we) m_d_rd = mem_val(m_addr);
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_wait == TO) begin
        m_phase = 2; m_err = 1;
        if (m_own_d) m_d_rd = 0; else m_if_rd = 0;
      end
`endif
    end else if (d_req_i && (!if_req_i || m_streak < MAXD)) begin
      m_phase = 1; m_own_d = 1; m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_wait = 0;
      m_streak = if_req_i ? m_streak + 1 : 0;
    end else if (if_req_i) begin
      m_phase = 1; m_own_d = 0; m_we = 0; m_addr = if_addr_i; m_wait = 0; m_streak = 0;
    end
  end

  // Per-cycle compare plus a grant log and pulse counters for the directed checks.
  bit prev_req = 0;
  int run = 0, last_run = 0, n_if_done = 0, n_d_done = 0;
  logic [31:0] log_addr[$], log_wd[$];
  bit log_we[$];
  always @(negedge clk_i) begin
    chk("mem_req", mem_req_o, m_phase == 1);
    if (m_phase == 1) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("if_done", if_done_o, m_phase == 2 && !m_own_d);
    chk("d_done", d_done_o, m_phase == 2 && m_own_d);
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("d_rdata", d_rdata_o, m_d_rd);
    chk("if_stall", if_stall_o, if_req_i && !(m_phase == 2 && !m_own_d));
    chk("err", err_o, m_err);
    if (mem_req_o && !prev_req) begin
      log_addr.push_back(mem_addr_o); log_we.push_back(mem_we_o); log_wd.push_back(mem_wdata_o);
    end
    if (mem_req_o) run++;
    else if (prev_req) begin last_run = run; run = 0; end
    n_if_done += int'(if_done_o);
    n_d_done += int'(d_done_o);
    prev_req = mem_req_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Waits for the requested done pulses, dropping each request inside its DONE cycle.
  task automatic wait_dones(input bit w_if, input bit w_d, input int limit);
    int t = 0;
    while ((w_if || w_d) && t < limit) begin
      @(negedge clk_i);
      t++;
      if (w_if && if_done_o) begin w_if = 0; #1 if_req_i = 0; end
      if (w_d && d_done_o) begin w_d = 0; #1 d_req_i = 0; end
    end
    if (w_if || w_d) begin
      chk("done_wait", {30'd0, w_if, w_d}, 0);
      if_req_i = 0; d_req_i = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, t, saved;
    cyc(2);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", {if_rdata_o | d_rdata_o}, 0);
    chk("rst_dones", {30'd0, if_done_o, d_done_o}, 0);
    chk("rst_err", err_o, 0);
    rst_n_i = 1; cyc(1);
    stray = 1; cyc(3);
    chk("stray_ack_req", mem_req_o, 0);
    chk("stray_ack_grants", log_addr.size(), 0);
    // single fetch
    if_addr_i = 32'h10; if_req_i = 1;
    wait_dones(1, 0, 20); cyc(2);
    chk("fetch_rdata", if_rdata_o, 32'h8C01_0004);
    chk("fetch_pulses", n_if_done, 1);
    chk("fetch_we", log_we[0], 0);
    chk("fetch_req_len", last_run, 1);
    // collision: write first, then fetch
    d_addr_i = 32'h40; d_we_i = 1; d_wdata_i = 32'hDEAD_BEEF; if_addr_i = 32'h14;
    d_req_i = 1; if_req_i = 1;
    wait_dones(1, 1, 40); cyc(2);
    chk("col_first_addr", log_addr[1], 32'h40);
    chk("col_first_we", log_we[1], 1);
    chk("col_first_wdata", log_wd[1], 32'hDEAD_BEEF);
    chk("col_second_addr", log_addr[2], 32'h14);
    chk("col_d_pulses", n_d_done, 1);
    chk("col_if_pulses", n_if_done, 2);
    chk("col_write_no_rdata", d_rdata_o, 0);
    // variable latency read
    ack_delay = 10; d_we_i = 0; d_addr_i = 32'h80; d_req_i = 1;
    wait_dones(0, 1, 40); cyc(2);
    chk("lat_req_len", last_run, 11);
    chk("lat_rdata", d_rdata_o, 32'h1000_0180);
    ack_delay = 0;
    // starvation bound
    d_addr_i = 32'h44; if_addr_i = 32'h18; base = log_addr.size();
    d_req_i = 1; if_req_i = 1;
    t = 0;
    while (log_addr.size() < base + 10 && t < 80) begin @(negedge clk_i); t++; end
    #1 d_req_i = 0; if_req_i = 0;
    chk("starve_wait", t < 80, 1);
    cyc(6);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_%0d", i), log_addr[base + i], (i % 5 == 4) ? 32'h18 : 32'h44);
    // reset mid transaction
    ack_delay = 20; d_addr_i = 32'h48; d_req_i = 1;
    cyc(4);
    chk("pre_rst_req", mem_req_o, 1);
    saved = n_d_done;
    rst_n_i = 0;
    #1 chk("rst_req_drop", mem_req_o, 0);
    d_req_i = 0;
    cyc(2); rst_n_i = 1; cyc(3);
    chk("rst_no_done", n_d_done, saved);
    chk("rst_d_rdata", d_rdata_o, 0);
    ack_delay = 0;
    // first grant after reset: data wins
    base = log_addr.size();
    d_addr_i = 32'h4C; if_addr_i = 32'h1C; d_req_i = 1; if_req_i = 1;
    wait_dones(1, 1, 40); cyc(2);
    chk("post_rst_first", log_addr[base], 32'h4C);
    chk("post_rst_second", log_addr[base + 1], 32'h1C);
    chk("post_rst_if_rdata", if_rdata_o, 32'h1000_0054);
`ifdef ARB_TIMEOUT_EN
    ack_en = 0; d_addr_i = 32'h50; d_req_i = 1;
    wait_dones(0, 1, 40); cyc(2);
    chk("to_rdata", d_rdata_o, 0);
    chk("to_err", err_o, 1);
    ack_en = 1; d_addr_i = 32'h54; d_req_i = 1;
    wait_dones(0, 1, 40); cyc(2);
    chk("to_next_rdata", d_rdata_o, 32'h1000_00FC);
    chk("to_err_sticky", err_o, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
